// File: rtl/sprite_rom_arbiter.sv
// Round-robin share of one synchronous sprite ROM port among NUM_REQ layers; tagged data returns ROM_LAT+1 cycles after gnt.
// No backpressure: one grant per cycle, requester holds req until it sees gnt. Define SPRITE_ARB_FIXED_PRIO_EN for absolute priority of requester 0.
// Latency: gnt/rom_address registered at edge T, rsp_valid/rsp_id/rsp_data registered at edge T+ROM_LAT+1.
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 2,
  parameter int ROM_LAT = 1,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      vga_clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [DATA_W-1:0]         rom_q,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data
);

  logic [ID_W-1:0]                 ptr;
  logic [ID_W-1:0]                 issue_id;
  logic [ROM_LAT-1:0]              pipe_vld;
  logic [ROM_LAT-1:0][ID_W-1:0]    pipe_id;

  logic                            win_vld;
  logic [ID_W-1:0]                 win_id;
  logic [ADDR_W-1:0]               win_addr;
  int                              rr_idx;

  // Search runs from farthest to nearest so the nearest active requester after ptr is assigned last.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    rr_idx  = 0;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
    for (int k = NUM_REQ - 1; k >= 1; k--) begin
      rr_idx = 1 + ((int'(ptr) - 1 + k) % (NUM_REQ - 1));
      if (req[ID_W'(rr_idx)]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(rr_idx);
      end
    end
    if (req[0]) begin
      win_vld = 1'b1;
      win_id  = '0;
    end
`else
    for (int k = NUM_REQ; k >= 1; k--) begin
      rr_idx = (int'(ptr) + k) % NUM_REQ;
      if (req[ID_W'(rr_idx)]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(rr_idx);
      end
    end
`endif
    win_addr = req_addr[int'(win_id)*ADDR_W +: ADDR_W];
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      gnt         <= '0;
      rom_address <= '0;
      ptr         <= ID_W'(NUM_REQ - 1);
      issue_id    <= '0;
      pipe_vld    <= '0;
      pipe_id     <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_data    <= '0;
    end else begin
      if (win_vld) begin
        gnt         <= NUM_REQ'(1) << win_id;
        rom_address <= win_addr;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
        // The background layer never moves the rotation among the other layers.
        if (win_id != '0)
          ptr <= win_id;
`else
        ptr <= win_id;
`endif
      end else begin
        gnt <= '0;
      end
      issue_id <= win_id;

      // Tag pipe: stage ROM_LAT-1 lines up with the cycle rom_q holds the granted word.
      pipe_vld[0] <= |gnt;
      pipe_id[0]  <= issue_id;
      for (int k = 1; k < ROM_LAT; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        pipe_id[k]  <= pipe_id[k-1];
      end

      rsp_valid <= pipe_vld[ROM_LAT-1];
      rsp_id    <= pipe_id[ROM_LAT-1];
      if (pipe_vld[ROM_LAT-1])
        rsp_data <= rom_q;
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed vector bench for sprite_rom_arbiter (NUM_REQ=4, ROM_LAT=1), ROM word = addr[1:0]^2'b01.
module tb_sprite_rom_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 2;
  localparam int ROM_LAT = 1;

  logic                      vga_clk = 1'b0;
  logic                      reset_n = 1'b0;
  logic [NUM_REQ-1:0]        req = 4'hF;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = {12'h0F2, 12'h0A3, 12'h021, 12'h010};
  logic [NUM_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]         rom_address;
  logic [DATA_W-1:0]         rom_q = '0;
  logic                      rsp_valid;
  logic [1:0]                rsp_id;
  logic [DATA_W-1:0]         rsp_data;

  int errors = 0;
  int checks = 0;

  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) rom_q <= rom_address[1:0] ^ 2'b01;

  sprite_rom_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .req(req), .req_addr(req_addr),
    .gnt(gnt), .rom_address(rom_address), .rom_q(rom_q),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [11:0] addr;
    logic        vld;
    logic [1:0]  id;
    logic [1:0]  data;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(logic r, logic [3:0] q, logic [3:0] g, logic [11:0] a,
                             logic vl, logic [1:0] id, logic [1:0] d);
    vec_t t;
    t.rst_n = r; t.req = q; t.gnt = g; t.addr = a; t.vld = vl; t.id = id; t.data = d;
    return t;
  endfunction

  // Independent ROM word for each requester's fixed address.
  function automatic logic [1:0] word_of(int id);
    case (id)
      0:       return 2'd1;
      1:       return 2'd0;
      2:       return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] hist [16];
    int         cnt  [4];
    int         exp_cnt [4];
    int         idx;
    bit         seen;

    // Three reset cycles with all requests up.
    for (int i = 0; i < 3; i++) vt.push_back(v(0, 4'hF, 4'h0, 12'h000, 0, 0, 0));
`ifdef SPRITE_ARB_FIXED_PRIO_EN
    vt.push_back(v(1, 4'hF, 4'h1, 12'h010, 0, 0, 0));
    vt.push_back(v(1, 4'hF, 4'h1, 12'h010, 0, 0, 0));
    vt.push_back(v(1, 4'hF, 4'h1, 12'h010, 1, 0, 1));
    vt.push_back(v(1, 4'hE, 4'h2, 12'h021, 1, 0, 1));
    vt.push_back(v(1, 4'hE, 4'h4, 12'h0A3, 1, 0, 1));
    vt.push_back(v(1, 4'hE, 4'h8, 12'h0F2, 1, 1, 0));
    vt.push_back(v(1, 4'hE, 4'h2, 12'h021, 1, 2, 2));
    vt.push_back(v(1, 4'hF, 4'h1, 12'h010, 1, 3, 3));
    vt.push_back(v(1, 4'hE, 4'h4, 12'h0A3, 1, 1, 0));
    vt.push_back(v(1, 4'h0, 4'h0, 12'h0A3, 1, 0, 1));
    vt.push_back(v(1, 4'h0, 4'h0, 12'h0A3, 1, 2, 2));
    vt.push_back(v(1, 4'h0, 4'h0, 12'h0A3, 0, 0, 0));
    exp_cnt = '{12, 0, 0, 0};
`else
    // All four requesting: rotation 0,1,2,3 with responses two cycles behind.
    vt.push_back(v(1, 4'hF, 4'h1, 12'h010, 0, 0, 0));
    vt.push_back(v(1, 4'hF, 4'h2, 12'h021, 0, 0, 0));
    vt.push_back(v(1, 4'hF, 4'h4, 12'h0A3, 1, 0, 1));
    vt.push_back(v(1, 4'hF, 4'h8, 12'h0F2, 1, 1, 0));
    vt.push_back(v(1, 4'hF, 4'h1, 12'h010, 1, 2, 2));
    vt.push_back(v(1, 4'hF, 4'h2, 12'h021, 1, 3, 3));
    vt.push_back(v(1, 4'hF, 4'h4, 12'h0A3, 1, 0, 1));
    vt.push_back(v(1, 4'hF, 4'h8, 12'h0F2, 1, 1, 0));
    // Single requester 2 wins every cycle.
    vt.push_back(v(1, 4'h4, 4'h4, 12'h0A3, 1, 2, 2));
    vt.push_back(v(1, 4'h4, 4'h4, 12'h0A3, 1, 3, 3));
    vt.push_back(v(1, 4'h4, 4'h4, 12'h0A3, 1, 2, 2));
    vt.push_back(v(1, 4'h4, 4'h4, 12'h0A3, 1, 2, 2));
    // req[1] pulsed for one cycle while requester 0 wins: forgotten.
    vt.push_back(v(1, 4'h8, 4'h8, 12'h0F2, 1, 2, 2));
    vt.push_back(v(1, 4'h3, 4'h1, 12'h010, 1, 2, 2));
    vt.push_back(v(1, 4'h0, 4'h0, 12'h010, 1, 3, 3));
    vt.push_back(v(1, 4'h0, 4'h0, 12'h010, 1, 0, 1));
    vt.push_back(v(1, 4'h0, 4'h0, 12'h010, 0, 0, 0));
    // Reset right after a grant to 3: its response is dropped, lowest active index wins next.
    vt.push_back(v(1, 4'h8, 4'h8, 12'h0F2, 0, 0, 0));
    vt.push_back(v(0, 4'hA, 4'h0, 12'h000, 0, 0, 0));
    vt.push_back(v(1, 4'hA, 4'h2, 12'h021, 0, 0, 0));
    vt.push_back(v(1, 4'hA, 4'h8, 12'h0F2, 0, 0, 0));
    vt.push_back(v(1, 4'h0, 4'h0, 12'h0F2, 1, 1, 0));
    vt.push_back(v(1, 4'h0, 4'h0, 12'h0F2, 1, 3, 3));
    vt.push_back(v(1, 4'h0, 4'h0, 12'h0F2, 0, 0, 0));
    exp_cnt = '{3, 3, 3, 3};
`endif

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge vga_clk);
      reset_n = vt[i].rst_n;
      req     = vt[i].req;
      @(posedge vga_clk);
      #1;
      check($sformatf("v%0d gnt", i), 32'(gnt), 32'(vt[i].gnt));
      check($sformatf("v%0d rom_address", i), 32'(rom_address), 32'(vt[i].addr));
      check($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(vt[i].vld));
      if (vt[i].vld || !vt[i].rst_n) begin
        check($sformatf("v%0d rsp_id", i), 32'(rsp_id), 32'(vt[i].id));
        check($sformatf("v%0d rsp_data", i), 32'(rsp_data), 32'(vt[i].data));
      end
    end

    // Sustained all-request run: grant counts, one-hot grants, responses in grant order.
    cnt = '{0, 0, 0, 0};
    for (int c = 0; c < 15; c++) begin
      @(negedge vga_clk);
      req = (c < 12) ? 4'hF : 4'h0;
      @(posedge vga_clk);
      #1;
      hist[c] = gnt;
      check($sformatf("burst c%0d onehot", c), 32'($onehot0(gnt)), 32'd1);
      for (int k = 0; k < 4; k++) if (gnt[k]) cnt[k]++;
      if (c >= 2) begin
        check($sformatf("burst c%0d rsp_valid", c), 32'(rsp_valid), 32'(hist[c-2] != 4'h0));
        if (hist[c-2] != 4'h0) begin
          idx = 0;
          for (int k = 0; k < 4; k++) if (hist[c-2][k]) idx = k;
          check($sformatf("burst c%0d rsp_id", c), 32'(rsp_id), 32'(idx));
          check($sformatf("burst c%0d rsp_data", c), 32'(rsp_data), 32'(word_of(idx)));
        end
      end
    end
    for (int k = 0; k < 4; k++)
      check($sformatf("burst grants id%0d", k), 32'(cnt[k]), 32'(exp_cnt[k]));

    // Lone requester 1: its response must arrive within a bounded number of cycles.
    @(negedge vga_clk);
    req  = 4'h2;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(posedge vga_clk);
      #1;
      if (rsp_valid && rsp_id == 2'd1) seen = 1'b1;
    end
    check("lone req1 response seen", 32'(seen), 32'd1);
    if (seen) check("lone req1 rsp_data", 32'(rsp_data), 32'(word_of(1)));
    @(negedge vga_clk);
    req = 4'h0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
